// File: rtl/lvds_rx_word_align.sv
// ---------------------------------------------------------------------------
// lvds_rx_word_align
//
// Receive-side word aligner behind the lvds_rx deserializer. The incoming
// 8-bit words carry an unknown bit rotation against the transmitter word
// boundary. A bit window slides over the last two words until the training
// pattern repeats LOCK_COUNT times. Once locked, the offset is frozen and
// every word is forwarded correctly framed.
//
// Ports:
//   clk         deserializer output clock, rising-edge logic
//   rst         asynchronous active-high reset
//   rx_data     raw deserialized word
//   rx_valid    rx_data accepted on this rising edge
//   relock      single-cycle request to restart alignment (offset kept)
//   data_out    aligned word
//   data_valid  data_out holds a new aligned word this cycle (LOCKED only)
//   locked      alignment achieved
//   bit_offset  current window offset
//   align_err   sticky: no lock within SLIP_LIMIT slips
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SEARCH  | slip the window one bit per mismatching word, count matches
// ST_LOCKED  | offset frozen, every evaluated word forwarded
// ---------------------------------------------------------------------------
module lvds_rx_word_align #(
    parameter logic [7:0] TRAIN_PATTERN = 8'hF0,
    parameter int         LOCK_COUNT    = 16,
    parameter int         SLIP_LIMIT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       relock,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       locked,
    output logic [2:0] bit_offset,
    output logic       align_err
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [7:0] LOCK_CNT8  = 8'(LOCK_COUNT);
    localparam logic [7:0] SLIP_LIM8  = 8'(SLIP_LIMIT);

    logic [0:0] state_q,      state_d;
    logic [7:0] prev_q,       prev_d;
    logic [7:0] cur_q,        cur_d;
    logic       v_d1_q,       v_d1_d;
    logic [2:0] offset_q,     offset_d;
    logic [7:0] match_cnt_q,  match_cnt_d;
    logic [7:0] slip_cnt_q,   slip_cnt_d;
    logic [7:0] data_out_q,   data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       locked_q,     locked_d;
    logic       align_err_q,  align_err_d;

    logic [15:0] cat_shift;
    logic [7:0]  window;
    logic [7:0]  match_inc;
    logic [7:0]  slip_inc;

    // Window = cat[7+offset : offset], offset 0 selects cur unchanged.
    assign cat_shift = {prev_q, cur_q} >> offset_q;
    assign window    = cat_shift[7:0];
    assign match_inc = match_cnt_q + 8'd1;
    assign slip_inc  = (slip_cnt_q == 8'hFF) ? 8'hFF : slip_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        v_d1_d       = rx_valid;
        offset_d     = offset_q;
        match_cnt_d  = match_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        locked_d     = locked_q;
        align_err_d  = align_err_q;

        // History shifts on every accepted word, relock or not.
        if (rx_valid) begin
            prev_d = cur_q;
            cur_d  = rx_data;
        end

        if (v_d1_q) begin
            data_out_d = window;
        end

        if (relock) begin
            // Any evaluation on this edge is dropped; offset deliberately kept.
            state_d     = ST_SEARCH;
            locked_d    = 1'b0;
            match_cnt_d = 8'd0;
            slip_cnt_d  = 8'd0;
            align_err_d = 1'b0;
        end else if (v_d1_q) begin
            case (state_q)
                ST_LOCKED: begin
                    data_valid_d = 1'b1;
                end
                default: begin
                    if (window == TRAIN_PATTERN) begin
                        if (match_inc == LOCK_CNT8) begin
                            state_d     = ST_LOCKED;
                            locked_d    = 1'b1;
                            match_cnt_d = 8'd0;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else begin
                        match_cnt_d = 8'd0;
                        offset_d    = offset_q + 3'd1;
                        slip_cnt_d  = slip_inc;
                        if (slip_inc >= SLIP_LIM8) begin
                            align_err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SEARCH;
            prev_q       <= 8'd0;
            cur_q        <= 8'd0;
            v_d1_q       <= 1'b0;
            offset_q     <= 3'd0;
            match_cnt_q  <= 8'd0;
            slip_cnt_q   <= 8'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            v_d1_q       <= v_d1_d;
            offset_q     <= offset_d;
            match_cnt_q  <= match_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            align_err_q  <= align_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;
    assign bit_offset = offset_q;
    assign align_err  = align_err_q;

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// ---------------------------------------------------------------------------
// tb_lvds_rx_word_align
//
// Directed bench for lvds_rx_word_align. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so every value read after
// tick() reflects the edge just taken.
//
// Received words for a transmitter stream T with the receiver needing
// offset 5 are R_n = {T_n[2:0], T_(n+1)[7:3]}: constant F0 gives 1E, and
// the stream F0 A5 3C F0 gives 14 A7 9E 1E.
// ---------------------------------------------------------------------------
module tb_lvds_rx_word_align;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       relock;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic [2:0] bit_offset;
    logic       align_err;

    int checks;
    int errors;

    lvds_rx_word_align #(
        .TRAIN_PATTERN(8'hF0),
        .LOCK_COUNT   (16),
        .SLIP_LIMIT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .relock    (relock),
        .data_out  (data_out),
        .data_valid(data_valid),
        .locked    (locked),
        .bit_offset(bit_offset),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        relock   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({data_out, data_valid, locked, bit_offset, align_err} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got do=%h dv=%b lk=%b off=%0d err=%b, expected all 0",
                     data_out, data_valid, locked, bit_offset, align_err);
        end
    endtask

    // Scenario 1: constant 1E, lock at offset 5 after 5 slips + 16 matches.
    task automatic test_rotated();
        do_reset();
        rx_data  = 8'h1E;
        rx_valid = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t == 1 || t == 2 || t == 3 || t == 6 || t == 21) begin
                logic [2:0] exp_off;
                exp_off = (t >= 6) ? 3'd5 : 3'(t - 1);
                checks++;
                if (bit_offset !== exp_off) begin
                    errors++;
                    $display("FAIL rot_offset_t%0d: got %0d, expected %0d", t, bit_offset, exp_off);
                end
            end
            if (t == 21) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL rot_early_lock: got locked=%b, expected 0", locked);
                end
            end
            if (t == 22) begin
                checks++;
                if ({locked, bit_offset, align_err, data_valid} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL rot_lock: got lk=%b off=%0d err=%b dv=%b, expected lk=1 off=5 err=0 dv=0",
                             locked, bit_offset, align_err, data_valid);
                end
            end
        end
    endtask

    // Scenario 2: payload A5, 3C framed by training words.
    task automatic test_payload();
        logic [7:0] stim  [0:4];
        logic [7:0] exp_d [0:4];
        stim[0] = 8'h14; exp_d[0] = 8'hF0;
        stim[1] = 8'hA7; exp_d[1] = 8'hF0;
        stim[2] = 8'h9E; exp_d[2] = 8'hA5;
        stim[3] = 8'h1E; exp_d[3] = 8'h3C;
        stim[4] = 8'h1E; exp_d[4] = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            rx_data  = stim[i];
            rx_valid = (i < 4);
            tick();
            checks++;
            if (data_valid !== 1'b1 || data_out !== exp_d[i]) begin
                errors++;
                $display("FAIL payload_%0d: got do=%h dv=%b, expected do=%h dv=1",
                         i, data_out, data_valid, exp_d[i]);
            end
        end
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL payload_dv_drop: got dv=%b, expected 0", data_valid);
        end
    endtask

    // Scenario 5: relock coincident with an accepted word while LOCKED.
    task automatic test_relock();
        rx_data  = 8'h1E;
        rx_valid = 1'b1;
        tick();
        relock = 1'b1;
        tick();
        relock = 1'b0;
        checks++;
        if ({locked, data_valid, bit_offset} !== {1'b0, 1'b0, 3'd5}) begin
            errors++;
            $display("FAIL relock_cycle: got lk=%b dv=%b off=%0d, expected lk=0 dv=0 off=5",
                     locked, data_valid, bit_offset);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) begin
                checks++;
                if (data_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL relock_search_dv: got dv=%b, expected 0", data_valid);
                end
            end
            if (i == 15) begin
                checks++;
                if ({locked, bit_offset} !== {1'b0, 3'd5}) begin
                    errors++;
                    $display("FAIL relock_early: got lk=%b off=%0d, expected lk=0 off=5", locked, bit_offset);
                end
            end
            if (i == 16) begin
                checks++;
                if ({locked, bit_offset, align_err} !== {1'b1, 3'd5, 1'b0}) begin
                    errors++;
                    $display("FAIL relock_lock: got lk=%b off=%0d err=%b, expected lk=1 off=5 err=0",
                             locked, bit_offset, align_err);
                end
            end
        end
    endtask

    // Scenario 6: async reset between edges while locked.
    task automatic test_reset_mid_lock();
        rx_data  = 8'h1E;
        rx_valid = 1'b1;
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hF0) begin
            errors++;
            $display("FAIL midrst_pre: got do=%h dv=%b, expected do=f0 dv=1", data_out, data_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({data_out, data_valid, locked, bit_offset, align_err} !== 14'd0) begin
            errors++;
            $display("FAIL midrst_async: got do=%h dv=%b lk=%b off=%0d err=%b, expected all 0",
                     data_out, data_valid, locked, bit_offset, align_err);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t == 1 || t == 2) begin
                checks++;
                if (bit_offset !== 3'(t - 1)) begin
                    errors++;
                    $display("FAIL midrst_offset_t%0d: got %0d, expected %0d", t, bit_offset, t - 1);
                end
            end
            if (t == 22) begin
                checks++;
                if ({locked, bit_offset} !== {1'b1, 3'd5}) begin
                    errors++;
                    $display("FAIL midrst_relock: got lk=%b off=%0d, expected lk=1 off=5", locked, bit_offset);
                end
            end
        end
    endtask

    // Scenario 3: no pattern, offset wraps and align_err sets after 16 slips.
    task automatic test_no_pattern();
        int dv_seen;
        int lk_seen;
        dv_seen = 0;
        lk_seen = 0;
        do_reset();
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (data_valid) dv_seen++;
            if (locked) lk_seen++;
            if (t == 8 || t == 9) begin
                logic [2:0] exp_off;
                exp_off = (t == 8) ? 3'd7 : 3'd0;
                checks++;
                if (bit_offset !== exp_off) begin
                    errors++;
                    $display("FAIL nopat_wrap_t%0d: got %0d, expected %0d", t, bit_offset, exp_off);
                end
            end
            if (t == 16 || t == 17 || t == 30) begin
                logic exp_err;
                exp_err = (t != 16);
                checks++;
                if (align_err !== exp_err) begin
                    errors++;
                    $display("FAIL nopat_err_t%0d: got %b, expected %b", t, align_err, exp_err);
                end
            end
        end
        checks++;
        if (dv_seen !== 0 || lk_seen !== 0) begin
            errors++;
            $display("FAIL nopat_quiet: got dv cycles=%0d lock cycles=%0d, expected 0 and 0", dv_seen, lk_seen);
        end
    endtask

    // Scenario 4: rx_valid alternating 1,0; lock after 21 accepted words.
    task automatic test_gapped();
        do_reset();
        rx_data = 8'h1E;
        for (int t = 1; t <= 44; t++) begin
            rx_valid = (t % 2 == 1);
            tick();
            if (t == 2 || t == 3 || t == 4) begin
                logic [2:0] exp_off;
                exp_off = (t == 4) ? 3'd2 : 3'd1;
                checks++;
                if (bit_offset !== exp_off) begin
                    errors++;
                    $display("FAIL gap_offset_t%0d: got %0d, expected %0d", t, bit_offset, exp_off);
                end
            end
            if (t == 41) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_early_lock: got %b, expected 0", locked);
                end
            end
            if (t == 42) begin
                checks++;
                if ({locked, bit_offset} !== {1'b1, 3'd5}) begin
                    errors++;
                    $display("FAIL gap_lock: got lk=%b off=%0d, expected lk=1 off=5", locked, bit_offset);
                end
            end
            if (t == 43) begin
                checks++;
                if (data_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_idle_dv: got %b, expected 0", data_valid);
                end
            end
            if (t == 44) begin
                checks++;
                if (data_valid !== 1'b1 || data_out !== 8'hF0) begin
                    errors++;
                    $display("FAIL gap_fwd: got do=%h dv=%b, expected do=f0 dv=1", data_out, data_valid);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        relock   = 1'b0;
        test_reset();
        test_rotated();
        test_payload();
        test_relock();
        test_reset_mid_lock();
        test_no_pattern();
        test_gapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
